// File: rtl/poly_pkg.sv
// Shared constants, opcodes and FSM state encoding for the coefficient-wise
// polynomial arithmetic pipeline.
package poly_pkg;

  localparam int Q       = 12289;
  localparam int W       = 16;
  localparam int R_BITS  = 18;
  // -Q^-1 mod 2^18, used by the Montgomery reduction
  localparam int QINV    = 12287;
  localparam int R_MOD_Q = 4075;

  localparam logic [1:0] OP_MULTIPLY         = 2'b00;
  localparam logic [1:0] OP_ADD              = 2'b01;
  localparam logic [1:0] OP_SUBTRACT         = 2'b10;
  localparam logic [1:0] OP_MULTIPLY_PRECOMP = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

endpackage

// File: rtl/poly_coeff_pipe_if.sv
// Control and RAM-side signal bundle of poly_coeff_pipe; the engine is the
// master, the controller/RAM side is the slave.
interface poly_coeff_pipe_if #(
  parameter int AW = 9,
  parameter int W  = 16
) ();

  logic          start;
  logic [1:0]    opCode;
  logic [AW-1:0] rd_base;
  logic [AW-1:0] wr_base;
  logic          busy;
  logic          done;
  logic [AW-1:0] ram_rd_addr;
  logic [W-1:0]  ram_doa;
  logic [W-1:0]  ram_dob;
  logic          ram_we;
  logic [AW-1:0] ram_wr_addr;
  logic [W-1:0]  dout;

  modport master (
    input  start, opCode, rd_base, wr_base, ram_doa, ram_dob,
    output busy, done, ram_rd_addr, ram_we, ram_wr_addr, dout
  );

  modport slave (
    output start, opCode, rd_base, wr_base, ram_doa, ram_dob,
    input  busy, done, ram_rd_addr, ram_we, ram_wr_addr, dout
  );

endinterface

// File: rtl/coeff_alu_pipe.sv
// Three-stage mod-Q ALU: operand products/sums, Barrett or Montgomery
// reduction to below 3Q, then a final conditional subtract into [0, Q).
module coeff_alu_pipe
  import poly_pkg::*;
#(
  parameter int W = poly_pkg::W,
  parameter int Q = poly_pkg::Q
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   opcode,
  input  logic         valid_in,
  output logic [W-1:0] result,
  output logic         valid_out
);

  localparam int QB = $clog2(Q);
  localparam int PW = 2 * QB;
  localparam int RW = QB + 2;
  localparam int MW = R_BITS + QB + 1;
  localparam int BM = (1 << PW) / Q;
  localparam logic [RW-1:0] Q1 = RW'(Q);
  localparam logic [RW-1:0] Q2 = RW'(2 * Q);

  logic          s1_valid, s2_valid;
  logic [1:0]    s1_op;
  logic [PW-1:0] s1_prod;
  logic [RW-1:0] s1_sum, s2_r;

  logic [PW-1:0]     prod;
  logic [RW-1:0]     sum;
  logic [QB:0]       qhat;
  logic [R_BITS-1:0] mont_m;
  logic [RW-1:0]     barrett_r, mont_r, s2_next, fin;

  always_comb begin
    prod = PW'(a) * PW'(b);
    if (opcode == OP_SUBTRACT) sum = RW'(a) + Q1 - RW'(b);
    else                       sum = RW'(a) + RW'(b);
  end

  // Both reductions leave a value below 3Q; add/sub just ride along
  always_comb begin
    qhat      = (QB+1)'(((PW+QB+1)'(s1_prod) * (PW+QB+1)'(BM)) >> PW);
    barrett_r = RW'(s1_prod - PW'(qhat) * PW'(Q));
    mont_m    = R_BITS'(s1_prod[R_BITS-1:0] * R_BITS'(QINV));
    mont_r    = RW'((MW'(s1_prod) + MW'(mont_m) * MW'(Q)) >> R_BITS);
    case (s1_op)
      OP_MULTIPLY:         s2_next = barrett_r;
      OP_MULTIPLY_PRECOMP: s2_next = mont_r;
      default:             s2_next = s1_sum;
    endcase
  end

  always_comb begin
    if (s2_r >= Q2)      fin = s2_r - Q2;
    else if (s2_r >= Q1) fin = s2_r - Q1;
    else                 fin = s2_r;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      valid_out <= 1'b0;
      s1_op     <= '0;
      s1_prod   <= '0;
      s1_sum    <= '0;
      s2_r      <= '0;
      result    <= '0;
    end else begin
      s1_valid  <= valid_in;
      s1_op     <= opcode;
      s1_prod   <= prod;
      s1_sum    <= sum;
      s2_valid  <= s1_valid;
      s2_r      <= s2_next;
      valid_out <= s2_valid;
      result    <= W'(fin);
    end
  end

endmodule

// File: rtl/poly_coeff_pipe.sv
// Streams N coefficient pairs from a dual-output RAM through the mod-Q ALU,
// writing one result per clock at a base-offset address.
module poly_coeff_pipe
  import poly_pkg::*;
#(
  parameter int N       = 512,
  parameter int AW      = 9,
  parameter int W       = poly_pkg::W,
  parameter int Q       = poly_pkg::Q,
  parameter int RAM_LAT = 1
) (
  input logic clk,
  input logic rst,
  poly_coeff_pipe_if.master bus
);

  localparam int LAT = RAM_LAT + 3;

  state_t        state, next_state;
  logic [1:0]    op_q;
  logic [AW-1:0] rd_ptr, wr_ptr, cnt;
  logic [LAT-1:0] vld_sr;
  logic          done_q, accept, drained;
  logic          alu_valid;
  logic [W-1:0]  alu_result;

  // The last element is in the ALU output register and nothing is behind it
  assign drained = vld_sr[LAT-1] && (vld_sr[LAT-2:0] == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          next_state = S_STREAM;
        end
      end
      S_STREAM: if (cnt == AW'(N - 1)) next_state = S_DRAIN;
      S_DRAIN:  if (drained) next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      vld_sr <= '0;
      done_q <= 1'b0;
    end else begin
      vld_sr <= {vld_sr[LAT-2:0], state == S_STREAM};
      done_q <= (state == S_DRAIN) && drained;
      if (accept) begin
        op_q   <= bus.opCode;
        rd_ptr <= bus.rd_base;
        cnt    <= '0;
      end else if (state == S_STREAM) begin
        rd_ptr <= rd_ptr + AW'(1);
        cnt    <= cnt + AW'(1);
      end
      if (accept)         wr_ptr <= bus.wr_base;
      else if (alu_valid) wr_ptr <= wr_ptr + AW'(1);
    end
  end

  coeff_alu_pipe #(.W(W), .Q(Q)) u_alu (
    .clk       (clk),
    .rst       (rst),
    .a         (bus.ram_doa),
    .b         (bus.ram_dob),
    .opcode    (op_q),
    .valid_in  (vld_sr[RAM_LAT-1]),
    .result    (alu_result),
    .valid_out (alu_valid)
  );

  assign bus.busy        = (state != S_IDLE);
  assign bus.done        = done_q;
  assign bus.ram_rd_addr = rd_ptr;
  assign bus.ram_wr_addr = wr_ptr;
  assign bus.ram_we      = alu_valid;
  assign bus.dout        = alu_result;

endmodule

// File: doc/poly_coeff_pipe.md
Name: poly_coeff_pipe

Overview:
- Parametrised, fully pipelined successor to the coefficient-wise polynomial arithmetic engine for the NewHope datapath.
- Streams N coefficient pairs from dual-output poly RAM and writes one result per cycle.
- Sustained throughput is 1 coeff/clk, instead of one coefficient per multi-cycle load/calc/unload loop.
- Supports add, subtract, modular multiply and Montgomery multiply with a precomputed operand. Addresses include base offsets, so any polynomial slot in a shared RAM can be targeted.

Parameters:
- N, 512, polynomial length; power of two, 512 or 1024.
- AW, 9, RAM address width; must be >= log2(N).
- W, 16, coefficient word width.
- Q, 12289, modulus.
- RAM_LAT, 1, RAM read latency in cycles (1 or 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins an operation when idle.
- opCode  in  2  00 MULTIPLY, 01 ADD, 10 SUBTRACT, 11 MULTIPLY_PRECOMP; sampled with start.
- rd_base  in  AW  read base address; sampled with start.
- wr_base  in  AW  write base address; sampled with start.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse after the last write.
- ram_rd_addr  out  AW  read address for both RAM ports.
- ram_doa  in  W  operand a.
- ram_dob  in  W  operand b.
- ram_we  out  1  write enable.
- ram_wr_addr  out  AW  write address.
- dout  out  W  result, valid when ram_we is high.

Behaviour:
- Clock and reset: one clock, clk; synchronous, active-high reset, rst.
- Reset values: busy=0, done=0, ram_we=0, ram_rd_addr=0, ram_wr_addr=0, dout=0. All pipeline valid bits are cleared.
- States: IDLE, STREAM, DRAIN.
- IDLE: start=1 latches opCode, rd_base and wr_base, then moves to STREAM. Call this cycle 0.
- STREAM: in cycle 1+k (k=0..N-1), ram_rd_addr = rd_base + k, mod 2^AW. After k=N-1, moves to DRAIN.
- LAT = RAM_LAT + 3. The arithmetic unit has a fixed 3-stage latency for every opcode; add and sub are delay-matched.
- Write side: ram_we=1 in cycles 1+LAT .. N+LAT. ram_wr_addr = wr_base + k, mod 2^AW, in cycle 1+k+LAT. dout carries result k in the same cycle.
- DRAIN: waits until the last valid bit exits the pipe, then returns to IDLE.
- busy: 1 in cycles 1 .. N+LAT.
- done: 1 in cycle N+LAT+1 only.
- Arithmetic: operands are required to be < Q; every result is < Q.
  - ADD: (a+b) mod Q, one conditional subtract of Q.
  - SUBTRACT: (a-b) mod Q, computed as a+Q-b then a conditional subtract.
  - MULTIPLY: a*b mod Q.
  - MULTIPLY_PRECOMP: a*b*2^-18 mod Q (Montgomery, R=2^18). b is pre-scaled by R.
  - All intermediates use full-width products (28 bits); there is no truncation before reduction.
- start while busy or in DRAIN: ignored. No queueing, and the latched opCode and bases are not disturbed.
- start in the same cycle as done: accepted (IDLE is re-entered combinationally with done). The next stream's cycle 0 is that cycle.
- opCode, rd_base and wr_base changing mid-operation: no effect.
- rst mid-operation: the next cycle is IDLE with all outputs at reset values. ram_we=0 immediately, so no partial write occurs after rst is sampled, and done is not issued.
- Base + k overflow: wraps modulo 2^AW.

Decomposition:
- Package poly_pkg holds:
  - Q, W, R_BITS=18, QINV (-Q^-1 mod 2^18), R_MOD_Q=4075.
  - opcode localparams OP_MULTIPLY, OP_ADD, OP_SUBTRACT, OP_MULTIPLY_PRECOMP.
  - state encodings.
- Sub-module coeff_alu_pipe: 3-stage mod-Q ALU.
  - Inputs: a, b, opcode, valid_in.
  - Outputs: result, valid_out.
  - Holds the Barrett and Montgomery reduction logic and the add/sub delay matching.
- The top level holds the FSM, address counters and valid shift register.

Test Plan:
- ADD, N=512, a[k]=12288, b[k]=1 -> all 512 writes dout=0. ram_wr_addr runs wr_base..wr_base+511 on cycles 1+LAT..512+LAT; done at cycle 513+LAT.
- SUBTRACT, a=0, b=1 -> dout=12288. MULTIPLY, a=12288, b=12288 -> dout=1. MULTIPLY, a=3, b=5 -> dout=15.
- MULTIPLY_PRECOMP, a=1, b=4075 -> dout=1. a=12288, b=4075 -> dout=12288.
- N=1024, AW=10, rd_base=1020 -> rd addresses wrap 1020..1023, 0..1019; exactly 1024 ram_we pulses; one done pulse.
- start pulsed at cycles 0 and 50, with a different opCode at cycle 50 -> the second start is ignored. All results use the first opCode, and a new start coincident with done is accepted.
- rst asserted at cycle 200 of a stream -> ram_we=0, busy=0 from cycle 201; no done pulse. A fresh start afterwards completes normally against a reference model.
